// File: rtl/acq_sequencer_pkg.sv
// Shared types and reset/address defaults for the acquisition sequencer.
// State encodings are visible on state_o and must stay stable for debug tooling.
package acq_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_SEND_A    = 3'd3,
    S_SEND_B    = 3'd4,
    S_HOLDOFF   = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic ch_b_en;
    logic ch_a_en;
    logic auto_rearm;
  } acq_mode_t;

  localparam int          ADDR_ACQ_MODE_DFLT = 0;
  localparam int          ADDR_HOLDOFF_DFLT  = 1;
  localparam int          ADDR_TIMEOUT_DFLT  = 2;
  localparam logic [2:0]  ACQ_MODE_RST       = 3'b110;
  localparam int          HOLDOFF_RST        = 0;
  localparam int          TIMEOUT_RST        = 0;
  localparam int          TIMEOUT_CNT_W      = 24;

endpackage

// File: rtl/acq_sequencer_seq_down_counter.sv
// Loadable down-counter with zero flag; stops at zero instead of wrapping.
module seq_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= value;
    else if (en && count != '0)
      count <= count - WIDTH'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arm -> wait trigger -> read ch A -> read ch B -> holdoff, optional auto-rearm.
// Optional trigger timeout / forced trigger is built only when ACQ_SEQ_TIMEOUT_EN is defined.
//
// state     | meaning
// IDLE      | waiting for host_start
// ARM       | one cycle, start_o pulsed to trigger block
// WAIT_TRIG | waiting for acq_done (optionally forcing a trigger)
// SEND_A    | channel A readout, exits on ch1_eof & ch1_ack
// SEND_B    | channel B readout, exits on ch2_eof & ch2_ack
// HOLDOFF   | dead time of holdoff+1 cycles before rearm or idle
module acq_sequencer
  import acq_sequencer_pkg::*;
#(
  parameter int         REG_ADDR_WIDTH   = 8,
  parameter int         REG_DATA_WIDTH   = 16,
  parameter int         ADDR_ACQ_MODE    = ADDR_ACQ_MODE_DFLT,
  parameter int         ADDR_HOLDOFF     = ADDR_HOLDOFF_DFLT,
  parameter int         ADDR_TIMEOUT     = ADDR_TIMEOUT_DFLT,
  parameter logic [2:0] DEFAULT_ACQ_MODE = ACQ_MODE_RST,
  parameter int         DEFAULT_HOLDOFF  = HOLDOFF_RST,
  parameter int         DEFAULT_TIMEOUT  = TIMEOUT_RST
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] register_addr,
  input  logic [REG_DATA_WIDTH-1:0] register_data,
  input  logic                      register_rdy,
  input  logic                      host_start,
  input  logic                      host_stop,
  input  logic                      acq_done,
  input  logic                      ch1_eof,
  input  logic                      ch1_ack,
  input  logic                      ch2_eof,
  input  logic                      ch2_ack,
  output logic                      start_o,
  output logic                      stop_o,
  output logic                      rqst_ch1_o,
  output logic                      rqst_ch2_o,
  output logic                      force_trig_o,
  output logic                      busy_o,
  output logic [2:0]                state_o
);

  seq_state_t                state;
  acq_mode_t                 mode;
  logic [REG_DATA_WIDTH-1:0] holdoff;
  logic                      hold_zero;
  logic                      timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode    <= acq_mode_t'(DEFAULT_ACQ_MODE);
      holdoff <= REG_DATA_WIDTH'(DEFAULT_HOLDOFF);
    end else if (register_rdy) begin
      if (register_addr == REG_ADDR_WIDTH'(ADDR_ACQ_MODE))
        mode <= acq_mode_t'(register_data[2:0]);
      if (register_addr == REG_ADDR_WIDTH'(ADDR_HOLDOFF))
        holdoff <= register_data;
    end
  end

  // Counter tracks the holdoff register while outside HOLDOFF, so it holds the right value on entry.
  seq_down_counter #(.WIDTH(REG_DATA_WIDTH)) u_holdoff_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (state != S_HOLDOFF),
    .en    (state == S_HOLDOFF),
    .value (holdoff),
    .zero  (hold_zero)
  );

`ifdef ACQ_SEQ_TIMEOUT_EN
  logic [15:0]              timeout;
  logic [TIMEOUT_CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      timeout <= 16'(DEFAULT_TIMEOUT);
    else if (register_rdy && register_addr == REG_ADDR_WIDTH'(ADDR_TIMEOUT))
      timeout <= 16'(register_data);
  end

  // Saturating so the forced trigger can only fire once per wait.
  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT_TRIG)
      wait_cnt <= '0;
    else if (wait_cnt != '1)
      wait_cnt <= wait_cnt + TIMEOUT_CNT_W'(1);
  end

  // Compared one count ahead so the registered pulse lines up with wait_cnt == target.
  assign timeout_hit = (timeout != 16'd0) &&
                       ((wait_cnt + TIMEOUT_CNT_W'(1)) == {timeout, 8'h00});
`else
  logic unused_timeout_cfg;
  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = ^{ADDR_TIMEOUT, DEFAULT_TIMEOUT};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      start_o      <= 1'b0;
      stop_o       <= 1'b0;
      rqst_ch1_o   <= 1'b0;
      rqst_ch2_o   <= 1'b0;
      force_trig_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      start_o      <= 1'b0;
      stop_o       <= 1'b0;
      rqst_ch1_o   <= 1'b0;
      rqst_ch2_o   <= 1'b0;
      force_trig_o <= 1'b0;
      if (state != S_IDLE && host_stop) begin
        state  <= S_IDLE;
        stop_o <= 1'b1;
        busy_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE:
            if (host_start) begin
              state   <= S_ARM;
              start_o <= 1'b1;
              busy_o  <= 1'b1;
            end
          S_ARM:
            state <= S_WAIT_TRIG;
          S_WAIT_TRIG:
            if (acq_done) begin
              if (mode.ch_a_en) begin
                state      <= S_SEND_A;
                rqst_ch1_o <= 1'b1;
              end else if (mode.ch_b_en) begin
                state      <= S_SEND_B;
                rqst_ch2_o <= 1'b1;
              end else begin
                state <= S_HOLDOFF;
              end
            end else begin
              force_trig_o <= timeout_hit;
            end
          S_SEND_A:
            if (ch1_eof && ch1_ack) begin
              if (mode.ch_b_en) begin
                state      <= S_SEND_B;
                rqst_ch2_o <= 1'b1;
              end else begin
                state <= S_HOLDOFF;
              end
            end
          S_SEND_B:
            if (ch2_eof && ch2_ack)
              state <= S_HOLDOFF;
          S_HOLDOFF:
            if (hold_zero) begin
              if (mode.auto_rearm) begin
                state   <= S_ARM;
                start_o <= 1'b1;
              end else begin
                state  <= S_IDLE;
                busy_o <= 1'b0;
              end
            end
          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: directed vector table, hand-written corner sequences,
// and randomized traffic compared every cycle against a behavioural model.
module tb_acq_sequencer;

  localparam int PH_IDLE = 0, PH_ARM = 1, PH_WAIT = 2, PH_A = 3, PH_B = 4, PH_HOLD = 5;

  // expected output word: {start, stop, rqst1, rqst2, force, busy, state[2:0]}
  localparam logic [8:0] E_IDLE  = 9'b0_0_0_0_0_0_000;
  localparam logic [8:0] E_ARM   = 9'b1_0_0_0_0_1_001;
  localparam logic [8:0] E_WAIT  = 9'b0_0_0_0_0_1_010;
  localparam logic [8:0] E_A_RQ  = 9'b0_0_1_0_0_1_011;
  localparam logic [8:0] E_A     = 9'b0_0_0_0_0_1_011;
  localparam logic [8:0] E_B_RQ  = 9'b0_0_0_1_0_1_100;
  localparam logic [8:0] E_B     = 9'b0_0_0_0_0_1_100;
  localparam logic [8:0] E_HOLD  = 9'b0_0_0_0_0_1_101;
  localparam logic [8:0] E_STOP  = 9'b0_1_0_0_0_0_000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  register_addr;
  logic [15:0] register_data;
  logic        register_rdy;
  logic        host_start, host_stop, acq_done;
  logic        ch1_eof, ch1_ack, ch2_eof, ch2_ack;
  logic        start_o, stop_o, rqst_ch1_o, rqst_ch2_o, force_trig_o, busy_o;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  acq_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .register_addr (register_addr),
    .register_data (register_data),
    .register_rdy  (register_rdy),
    .host_start    (host_start),
    .host_stop     (host_stop),
    .acq_done      (acq_done),
    .ch1_eof       (ch1_eof),
    .ch1_ack       (ch1_ack),
    .ch2_eof       (ch2_eof),
    .ch2_ack       (ch2_ack),
    .start_o       (start_o),
    .stop_o        (stop_o),
    .rqst_ch1_o    (rqst_ch1_o),
    .rqst_ch2_o    (rqst_ch2_o),
    .force_trig_o  (force_trig_o),
    .busy_o        (busy_o),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural reference model ----------------
  int          m_ph = PH_IDLE;
  int          m_hold_left = 0;
  int          m_widx = 0;
  logic [2:0]  m_mode = 3'b110;
  logic [15:0] m_holdoff = 16'd0;
  logic [15:0] m_timeout = 16'd0;
  logic [8:0]  m_exp = 9'd0;

  task automatic model_step();
    logic st, sp, r1, r2, fr;
    int   nph;
    st = 0; sp = 0; r1 = 0; r2 = 0; fr = 0;
    if (rst) begin
      m_ph = PH_IDLE; m_mode = 3'b110; m_holdoff = 0; m_timeout = 0;
      m_exp = E_IDLE;
    end else begin
      nph = m_ph;
      if (m_ph != PH_IDLE && host_stop) begin
        nph = PH_IDLE; sp = 1;
      end else begin
        case (m_ph)
          PH_IDLE: if (host_start) begin nph = PH_ARM; st = 1; end
          PH_ARM: begin nph = PH_WAIT; m_widx = 0; end
          PH_WAIT:
            if (acq_done) begin
              if (m_mode[1]) begin nph = PH_A; r1 = 1; end
              else if (m_mode[2]) begin nph = PH_B; r2 = 1; end
              else begin nph = PH_HOLD; m_hold_left = m_holdoff; end
            end else begin
              m_widx++;
`ifdef ACQ_SEQ_TIMEOUT_EN
              if (m_timeout != 0 && m_widx == int'(m_timeout) * 256) fr = 1;
`endif
            end
          PH_A:
            if (ch1_eof && ch1_ack) begin
              if (m_mode[2]) begin nph = PH_B; r2 = 1; end
              else begin nph = PH_HOLD; m_hold_left = m_holdoff; end
            end
          PH_B:
            if (ch2_eof && ch2_ack) begin nph = PH_HOLD; m_hold_left = m_holdoff; end
          PH_HOLD:
            if (m_hold_left == 0) begin
              if (m_mode[0]) begin nph = PH_ARM; st = 1; end
              else nph = PH_IDLE;
            end else m_hold_left--;
          default: nph = PH_IDLE;
        endcase
      end
      if (register_rdy) begin
        if (register_addr == 8'd0) m_mode = register_data[2:0];
        if (register_addr == 8'd1) m_holdoff = register_data;
`ifdef ACQ_SEQ_TIMEOUT_EN
        if (register_addr == 8'd2) m_timeout = register_data;
`endif
      end
      m_ph  = nph;
      m_exp = {st, sp, r1, r2, fr, (nph != PH_IDLE), 3'(nph)};
    end
  endtask

  function automatic logic [8:0] outs();
    return {start_o, stop_o, rqst_ch1_o, rqst_ch2_o, force_trig_o, busy_o, state_o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model", 32'(outs()), 32'(m_exp));
  endtask

  task automatic clear_in();
    rst = 0; register_rdy = 0; register_addr = 0; register_data = 0;
    host_start = 0; host_stop = 0; acq_done = 0;
    ch1_eof = 0; ch1_ack = 0; ch2_eof = 0; ch2_ack = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    register_rdy = 1; register_addr = a; register_data = d;
    tick();
    register_rdy = 0;
  endtask

  typedef struct {
    logic       rst, start, stop, done, e1, a1, e2, a2;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[23];

  initial begin
    int n, seen, fcnt, ffirst;

    vecs[0]  = '{1,0,0,0,0,0,0,0, E_IDLE};
    vecs[1]  = '{0,0,0,0,0,0,0,0, E_IDLE};
    vecs[2]  = '{0,1,0,0,0,0,0,0, E_ARM};
    vecs[3]  = '{0,0,0,0,0,0,0,0, E_WAIT};
    vecs[4]  = '{0,0,0,0,0,0,0,0, E_WAIT};
    vecs[5]  = '{0,0,0,1,0,0,0,0, E_A_RQ};
    vecs[6]  = '{0,0,0,0,1,0,0,0, E_A};
    vecs[7]  = '{0,0,0,0,1,1,0,0, E_B_RQ};
    vecs[8]  = '{0,0,0,0,0,0,0,1, E_B};
    vecs[9]  = '{0,0,0,0,0,0,1,1, E_HOLD};
    vecs[10] = '{0,0,0,0,0,0,0,0, E_IDLE};
    vecs[11] = '{0,0,1,0,0,0,0,0, E_IDLE};
    vecs[12] = '{0,1,0,0,0,0,0,0, E_ARM};
    vecs[13] = '{0,0,0,1,0,0,0,0, E_WAIT};
    vecs[14] = '{0,0,1,1,0,0,0,0, E_STOP};
    vecs[15] = '{0,0,0,0,0,0,0,0, E_IDLE};
    vecs[16] = '{0,1,1,0,0,0,0,0, E_ARM};
    vecs[17] = '{0,0,1,0,0,0,0,0, E_STOP};
    vecs[18] = '{0,1,0,0,0,0,0,0, E_ARM};
    vecs[19] = '{0,0,0,0,0,0,0,0, E_WAIT};
    vecs[20] = '{0,0,0,1,0,0,0,0, E_A_RQ};
    vecs[21] = '{1,0,0,0,0,0,0,0, E_IDLE};
    vecs[22] = '{0,0,0,0,0,0,0,0, E_IDLE};

    clear_in();
    for (int i = 0; i < 23; i++) begin
      rst = vecs[i].rst; host_start = vecs[i].start; host_stop = vecs[i].stop;
      acq_done = vecs[i].done; ch1_eof = vecs[i].e1; ch1_ack = vecs[i].a1;
      ch2_eof = vecs[i].e2; ch2_ack = vecs[i].a2;
      tick();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    clear_in();

    // Default mode, acq_done 10 cycles after start_o.
    host_start = 1; tick(); host_start = 0;
    chk("dflt_start", 32'(outs()), 32'(E_ARM));
    for (int i = 0; i < 9; i++) tick();
    acq_done = 1; tick(); acq_done = 0;
    chk("dflt_rq1", 32'(outs()), 32'(E_A_RQ));
    ch1_eof = 1; ch1_ack = 1; tick(); ch1_eof = 0; ch1_ack = 0;
    chk("dflt_rq2", 32'(outs()), 32'(E_B_RQ));
    ch2_eof = 1; ch2_ack = 1; tick(); ch2_eof = 0; ch2_ack = 0;
    chk("dflt_hold", 32'(outs()), 32'(E_HOLD));
    tick();
    chk("dflt_idle", 32'(outs()), 32'(E_IDLE));

    // Auto-rearm, channel B only, holdoff 5.
    wr(8'd0, 16'h0005); wr(8'd1, 16'd5);
    host_start = 1; tick(); host_start = 0;
    chk("auto_arm", 32'(start_o), 32'd1);
    tick();
    acq_done = 1; tick(); acq_done = 0;
    chk("auto_rq", 32'({rqst_ch1_o, rqst_ch2_o}), 32'b01);
    tick(); tick();
    ch2_eof = 1; ch2_ack = 1; tick(); ch2_eof = 0; ch2_ack = 0;
    n = 0; seen = 0;
    while (!start_o && n < 20) begin
      tick(); n++;
      if (rqst_ch1_o) seen = 1;
    end
    chk("auto_rearm_delay", 32'(n), 32'd6);
    chk("auto_no_rq1", 32'(seen), 32'd0);
    tick();
    host_stop = 1; tick(); host_stop = 0;
    chk("auto_stop", 32'({stop_o, busy_o, state_o}), 32'b10000);
    tick();
    chk("auto_idle", 32'(outs()), 32'(E_IDLE));

    // Mode 0: straight to holdoff without requests.
    wr(8'd0, 16'h0000); wr(8'd1, 16'd0);
    host_start = 1; tick(); host_start = 0;
    tick();
    acq_done = 1; tick(); acq_done = 0;
    chk("m0_hold", 32'(outs()), 32'(E_HOLD));
    tick();
    chk("m0_idle", 32'(outs()), 32'(E_IDLE));

    // Trigger timeout = 1 (256 cycles), then timeout = 0.
    wr(8'd0, 16'h0006); wr(8'd2, 16'd1);
    for (int pass = 0; pass < 2; pass++) begin
      host_start = 1; tick(); host_start = 0;
      tick();
      fcnt = 0; ffirst = -1;
      for (int i = 1; i <= 600; i++) begin
        tick();
        if (force_trig_o) begin
          fcnt++;
          if (ffirst < 0) ffirst = i;
        end
      end
`ifdef ACQ_SEQ_TIMEOUT_EN
      if (pass == 0) begin
        chk("to_first", 32'(ffirst), 32'd256);
        chk("to_count", 32'(fcnt), 32'd1);
      end else begin
        chk("to_zero_count", 32'(fcnt), 32'd0);
      end
`else
      chk("to_disabled_count", 32'(fcnt), 32'd0);
`endif
      host_stop = 1; tick(); host_stop = 0;
      chk("to_stop", 32'(outs()), 32'(E_STOP));
      wr(8'd2, 16'd0);
    end

    // Randomized traffic against the model.
    begin
      int done_pct;
      done_pct = 20;
      rst = 1; tick(); rst = 0;
      for (int c = 0; c < 4000; c++) begin
        if (c % 256 == 0) begin
          case ($urandom_range(0, 2))
            0: done_pct = 0;
            1: done_pct = 5;
            default: done_pct = 30;
          endcase
        end
        rst        = ($urandom_range(0, 199) == 0);
        host_start = ($urandom_range(0, 9) == 0);
        host_stop  = ($urandom_range(0, 49) == 0);
        acq_done   = ($urandom_range(0, 99) < done_pct);
        ch1_eof    = $urandom_range(0, 1) == 1;
        ch1_ack    = $urandom_range(0, 1) == 1;
        ch2_eof    = $urandom_range(0, 1) == 1;
        ch2_ack    = $urandom_range(0, 1) == 1;
        register_rdy  = ($urandom_range(0, 15) == 0);
        register_addr = 8'($urandom_range(0, 3));
        case (register_addr)
          8'd1:    register_data = 16'($urandom_range(0, 7));
          8'd2:    register_data = 16'($urandom_range(0, 1));
          default: register_data = 16'($urandom_range(0, 255));
        endcase
        tick();
      end
      clear_in();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acq_sequencer.md
# acq_sequencer

Acquisition sequencer between the host request decoder, the trigger block and the two channel blocks. It turns a single host start into a full arm → wait-for-trigger → read channel A → read channel B → holdoff cycle. When auto-rearm is enabled it repeats that cycle until the host issues a stop. It sits on the shared register bus and drives the same start/stop/data-request strobes the host decoder produces today.

## Interface
Parameters:
- REG_ADDR_WIDTH, `__REG_ADDR_WIDTH: register bus address width
- REG_DATA_WIDTH, `__REG_DATA_WIDTH (16): register bus data width
- ADDR_ACQ_MODE, `__ADDR_ACQ_MODE: mode register address
  - bit0: auto_rearm
  - bit1: chA_en
  - bit2: chB_en
  - bits above 2: ignored
- ADDR_HOLDOFF, `__ADDR_HOLDOFF: holdoff register address, in clk cycles
- ADDR_TIMEOUT, `__ADDR_TIMEOUT: trigger timeout register address, in units of 256 cycles
- DEFAULT_ACQ_MODE, 3'b110: reset value of the mode register
- DEFAULT_HOLDOFF, 0: reset value of the holdoff register
- DEFAULT_TIMEOUT, 0: reset value of the timeout register; 0 disables the timeout

Ports:
- clk  in  1  system clock (100 MHz PLL output)
- rst  in  1  reset; synchronous, active-high
- register_addr  in  REG_ADDR_WIDTH  register bus address
- register_data  in  REG_DATA_WIDTH  register bus data
- register_rdy  in  1  register bus write strobe
- host_start  in  1  start pulse from the request decoder
- host_stop  in  1  stop pulse from the request decoder
- acq_done  in  1  level from the trigger block: post-trigger samples are captured
- ch1_eof, ch1_ack  in  1 each  channel A tx handshake, monitored only
- ch2_eof, ch2_ack  in  1 each  channel B tx handshake, monitored only
- start_o  out  1  one-cycle arm pulse to the trigger block
- stop_o  out  1  one-cycle stop pulse to the trigger block
- rqst_ch1_o, rqst_ch2_o  out  1 each  one-cycle data request pulses to the channel blocks
- force_trig_o  out  1  one-cycle forced-trigger pulse
- busy_o  out  1  high whenever the state is not IDLE
- state_o  out  3  current state encoding, for debug

## Operation
- Register writes: when register_rdy is high and register_addr matches, the register loads register_data. The new value takes effect the following cycle.
- States: IDLE, ARM, WAIT_TRIG, SEND_A, SEND_B, HOLDOFF.
- IDLE → ARM on host_start.
- ARM lasts exactly one cycle and asserts start_o. Next state is WAIT_TRIG.
- WAIT_TRIG → SEND_A on acq_done if chA_en; else → SEND_B if chB_en; else → HOLDOFF.
- SEND_A: rqst_ch1_o pulses in the first cycle of the state. The state exits on the cycle where ch1_eof & ch1_ack are both high. Next state is SEND_B if chB_en, else HOLDOFF.
- SEND_B: same rule using rqst_ch2_o, ch2_eof and ch2_ack. Next state is HOLDOFF.
- HOLDOFF: a down-counter is loaded with the holdoff register on entry and decrements each cycle.
  - When the count is 0, the state goes to ARM if auto_rearm, else to IDLE.
  - Holdoff 0 gives exactly one HOLDOFF cycle.
- Mode bits are sampled at each decision point. Changing the mode mid-run affects only later decisions.
- host_stop in any state other than IDLE:
  - stop_o pulses in the following cycle and the state goes to IDLE.
  - host_stop has priority over a simultaneous acq_done, eof or holdoff expiry.
- host_stop in IDLE is ignored and no stop_o is issued. host_start in any state other than IDLE is ignored.

## Timing
- Reset values:
  - state: IDLE
  - all outputs: 0
  - state_o: 3'd0 (IDLE)
  - registers: their DEFAULT_ values
- All outputs are registered.
- host_start sampled at cycle n → start_o high at n+1 → busy_o high at n+1 → WAIT_TRIG at n+2.
- acq_done sampled at cycle n → rqst_ch1_o high at n+1.
- Strobes are never asserted for more than one cycle, and never two different strobes in the same cycle.
- rst mid-operation: state returns to IDLE in the next cycle. No stop_o is generated.

## Configuration
- ACQ_SEQ_TIMEOUT_EN defined:
  - In WAIT_TRIG a 24-bit counter runs from 0. When it equals {timeout,8'h00}, with timeout nonzero, force_trig_o pulses once.
  - The state stays in WAIT_TRIG until acq_done. The counter is cleared on entry to WAIT_TRIG.
- ACQ_SEQ_TIMEOUT_EN undefined:
  - force_trig_o is tied to 0.
  - ADDR_TIMEOUT writes are ignored and no counter is synthesised.

## Structure
- HDL_defines.v holds:
  - the `__ADDR_ACQ_MODE, `__ADDR_HOLDOFF, `__ADDR_TIMEOUT addresses and their defaults
  - localparam state encodings: IDLE=0, ARM=1, WAIT_TRIG=2, SEND_A=3, SEND_B=4, HOLDOFF=5
- One sub-module, seq_down_counter: a loadable down-counter with a zero flag, used for holdoff.

## Test plan
- Defaults, host_start, acq_done 10 cycles after start_o, then eof&ack on ch1 and ch2 → exactly one start_o, then rqst_ch1_o, then rqst_ch2_o, then IDLE; busy_o falls one cycle after holdoff.
- Mode=3'b101 (auto, chB only), holdoff=5 → rqst_ch1_o never pulses; start_o re-pulses 6 cycles after the ch2 eof&ack; host_stop then gives stop_o and IDLE.
- host_stop in the same cycle as acq_done → stop_o pulses, no rqst_ch*_o, IDLE.
- Mode=0 → the WAIT_TRIG→HOLDOFF path is taken with no requests issued.
- With ACQ_SEQ_TIMEOUT_EN, timeout=1, no acq_done → force_trig_o pulses once, 256 cycles after entering WAIT_TRIG. With timeout=0 → no pulse.
- rst asserted during SEND_A → all outputs 0 and state_o=0 the next cycle, no stop_o.
